// File: rtl/atomic_mem_sequencer.sv
// atomic_mem_sequencer
//   Sequences word-sized data-memory requests (LOAD, STORE, LR, SC and the RV32A
//   read-modify-write AMOs) for the barrel core. One request is in flight at a time;
//   every accepted request produces exactly one response tagged with its hart.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_req_*/o_req_ready   request handshake (accepted when valid && ready)
//   o_mem_*/i_mem_rdata   single-port data memory; read data arrives one cycle after
//                         the read strobe
//   o_rs_*/i_sc_success   reservation-set control; i_sc_success is registered by the
//                         reservation set and valid the cycle after o_rs_store_cond_op
//   o_resp_*              one-cycle response pulse, no backpressure
module atomic_mem_sequencer #(
  parameter int unsigned NUM_THREADS = 16,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned HART_W     = $clog2(NUM_THREADS)
) (
  input  logic                  clk,
  input  logic                  reset,
  // request
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [3:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [HART_W-1:0]     i_req_hartid,
  // data memory
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  // reservation set
  output logic [ADDR_WIDTH-1:0] o_rs_addr,
  output logic                  o_rs_store_op,
  output logic                  o_rs_store_cond_op,
  output logic                  o_rs_load_reserved_op,
  output logic [HART_W-1:0]     o_rs_mhartid,
  input  logic                  i_sc_success,
  // response
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic [HART_W-1:0]     o_resp_hartid,
  output logic                  o_resp_err
);

  localparam logic [3:0] OpLoad  = 4'd0;
  localparam logic [3:0] OpStore = 4'd1;
  localparam logic [3:0] OpLr    = 4'd2;
  localparam logic [3:0] OpSc    = 4'd3;
  localparam logic [3:0] OpSwap  = 4'd4;
  localparam logic [3:0] OpAdd   = 4'd5;
  localparam logic [3:0] OpXor   = 4'd6;
  localparam logic [3:0] OpAnd   = 4'd7;
  localparam logic [3:0] OpOr    = 4'd8;
  localparam logic [3:0] OpMin   = 4'd9;
  localparam logic [3:0] OpMax   = 4'd10;
  localparam logic [3:0] OpMinu  = 4'd11;
  localparam logic [3:0] OpMaxu  = 4'd12;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdw,
    StWr,
    StSc,
    StScr,
    StRsp
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  // Holds the request operand, and is overwritten with the AMO result once the old
  // value is known, so WR always writes this register.
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [HART_W-1:0]     hartid_q, hartid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  err_q, err_d;

  function automatic logic is_amo(input logic [3:0] op);
    return (op >= OpSwap) && (op <= OpMaxu);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OpMaxu;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] amo_result(input logic [3:0]            op,
                                                       input logic [DATA_WIDTH-1:0] old_val,
                                                       input logic [DATA_WIDTH-1:0] operand);
    logic                  s_lt, s_gt, u_lt, u_gt;
    logic [DATA_WIDTH-1:0] res;
    s_lt = $signed(operand) < $signed(old_val);
    s_gt = $signed(operand) > $signed(old_val);
    u_lt = operand < old_val;
    u_gt = operand > old_val;
    res  = old_val;
    case (op)
      OpSwap:  res = operand;
      OpAdd:   res = old_val + operand;
      OpXor:   res = old_val ^ operand;
      OpAnd:   res = old_val & operand;
      OpOr:    res = old_val | operand;
      // Strict compares so that equal values keep the old word.
      OpMin:   res = s_lt ? operand : old_val;
      OpMax:   res = s_gt ? operand : old_val;
      OpMinu:  res = u_lt ? operand : old_val;
      OpMaxu:  res = u_gt ? operand : old_val;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          if (!is_legal(i_req_op)) begin
            state_d = StRsp;
          end else if (i_req_op == OpStore) begin
            state_d = StWr;
          end else if (i_req_op == OpSc) begin
            state_d = StSc;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = StRdw;
      StRdw:   state_d = is_amo(op_q) ? StWr : StRsp;
      StWr:    state_d = StRsp;
      StSc:    state_d = StScr;
      StScr:   state_d = i_sc_success ? StWr : StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch and datapath next-state
  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hartid_d    = hartid_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          op_d        = i_req_op;
          addr_d      = i_req_addr;
          wdata_d     = i_req_wdata;
          hartid_d    = i_req_hartid;
          resp_data_d = '0;
          err_d       = !is_legal(i_req_op);
        end
      end
      StRdw: begin
        // Old word is the response for LOAD, LR and every AMO.
        resp_data_d = i_mem_rdata;
        if (is_amo(op_q)) begin
          wdata_d = amo_result(op_q, i_mem_rdata, wdata_q);
        end
      end
      StScr: begin
        // SC reports 0 on success, 1 on failure.
        resp_data_d = {{(DATA_WIDTH-1){1'b0}}, ~i_sc_success};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OpLoad;
      addr_q      <= '0;
      wdata_q     <= '0;
      hartid_q    <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hartid_q    <= hartid_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // Outputs: decoded from registered state and latched request only
  always_comb begin
    o_req_ready           = (state_q == StIdle);
    o_mem_en              = (state_q == StRd) || (state_q == StWr);
    o_mem_we              = (state_q == StWr);
    o_mem_addr            = addr_q;
    o_mem_wdata           = (state_q == StWr) ? wdata_q : '0;
    o_rs_addr             = addr_q;
    o_rs_mhartid          = hartid_q;
    o_rs_store_op         = (state_q == StWr);
    o_rs_store_cond_op    = (state_q == StSc);
    o_rs_load_reserved_op = (state_q == StRd) && (op_q == OpLr);
    o_resp_valid          = (state_q == StRsp);
    o_resp_data           = (state_q == StRsp) ? resp_data_q : '0;
    o_resp_hartid         = hartid_q;
    o_resp_err            = (state_q == StRsp) && err_q;
  end

endmodule

// File: tb/tb_atomic_mem_sequencer.sv
// Bench for atomic_mem_sequencer: behavioural memory and reservation set around the
// DUT, a transaction-level reference model feeding response and write scoreboards.
module tb_atomic_mem_sequencer;

  localparam int NT = 16;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready;
  logic [3:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [HW-1:0] req_hartid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW-1:0] rs_addr;
  logic          rs_store_op, rs_store_cond_op, rs_load_reserved_op;
  logic [HW-1:0] rs_mhartid;
  logic          sc_success;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_data;
  logic [HW-1:0] resp_hartid;

  always #5 clk = ~clk;

  atomic_mem_sequencer #(
    .NUM_THREADS(NT),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_req_valid          (req_valid),
    .o_req_ready          (req_ready),
    .i_req_op             (req_op),
    .i_req_addr           (req_addr),
    .i_req_wdata          (req_wdata),
    .i_req_hartid         (req_hartid),
    .o_mem_en             (mem_en),
    .o_mem_we             (mem_we),
    .o_mem_addr           (mem_addr),
    .o_mem_wdata          (mem_wdata),
    .i_mem_rdata          (mem_rdata),
    .o_rs_addr            (rs_addr),
    .o_rs_store_op        (rs_store_op),
    .o_rs_store_cond_op   (rs_store_cond_op),
    .o_rs_load_reserved_op(rs_load_reserved_op),
    .o_rs_mhartid         (rs_mhartid),
    .i_sc_success         (sc_success),
    .o_resp_valid         (resp_valid),
    .o_resp_data          (resp_data),
    .o_resp_hartid        (resp_hartid),
    .o_resp_err           (resp_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- environment: memory and reservation set ----------------
  logic [DW-1:0] env_mem [4096];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) env_mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
    // Junk on the read bus except the cycle after a read strobe.
    if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
    else mem_rdata <= DW'($urandom());
  end

  bit            rs_v [NT];
  logic [AW-1:0] rs_a [NT];

  always @(posedge clk) begin
    sc_success <= 1'b0;
    if (rs_load_reserved_op) begin
      rs_v[rs_mhartid] <= 1'b1;
      rs_a[rs_mhartid] <= rs_addr;
    end
    if (rs_store_cond_op) begin
      sc_success <= rs_v[rs_mhartid] && (rs_a[rs_mhartid] == rs_addr);
      rs_v[rs_mhartid] <= 1'b0;
    end
    if (rs_store_op) begin
      for (int t = 0; t < NT; t++) if (rs_v[t] && rs_a[t] == rs_addr) rs_v[t] <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [4096];
  bit            ref_v [NT];
  logic [AW-1:0] ref_a [NT];

  typedef struct {
    logic [DW-1:0] data;
    logic [HW-1:0] hart;
    logic          err;
    int            acc;
    int            lat;
  } exp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  exp_t expq[$];
  wr_t  wrq[$];

  function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wrq.push_back(w);
    ref_mem[a] = d;
    for (int t = 0; t < NT; t++) if (ref_v[t] && ref_a[t] == a) ref_v[t] = 1'b0;
  endfunction

  function automatic logic [DW-1:0] amo_ref(input logic [3:0] op, input logic [DW-1:0] old,
                                            input logic [DW-1:0] w);
    longint so = longint'($signed(old));
    longint sw = longint'($signed(w));
    longint uo = longint'({32'b0, old});
    longint uw = longint'({32'b0, w});
    case (op)
      4'd4:    return w;
      4'd5:    return DW'(uo + uw);
      4'd6:    return old ^ w;
      4'd7:    return old & w;
      4'd8:    return old | w;
      4'd9:    return (sw < so) ? w : old;
      4'd10:   return (sw > so) ? w : old;
      4'd11:   return (uw < uo) ? w : old;
      default: return (uw > uo) ? w : old;
    endcase
  endfunction

  task automatic model(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] w,
                       input logic [HW-1:0] h, output exp_t e);
    logic [DW-1:0] old;
    bit ok;
    e.hart = h;
    e.err  = 1'b0;
    e.data = '0;
    if (op == 4'd0) begin
      e.data = ref_mem[a]; e.lat = 3;
    end else if (op == 4'd1) begin
      ref_write(a, w); e.lat = 2;
    end else if (op == 4'd2) begin
      e.data = ref_mem[a]; ref_v[h] = 1'b1; ref_a[h] = a; e.lat = 3;
    end else if (op == 4'd3) begin
      ok = ref_v[h] && (ref_a[h] == a);
      ref_v[h] = 1'b0;
      if (ok) begin
        ref_write(a, w); e.lat = 4;
      end else begin
        e.data = 1; e.lat = 3;
      end
    end else if (op <= 4'd12) begin
      old = ref_mem[a];
      ref_write(a, amo_ref(op, old, w));
      e.data = old; e.lat = 4;
    end else begin
      e.err = 1'b1; e.lat = 1;
    end
  endtask

  // ---------------- monitors ----------------
  exp_t mon_e;
  wr_t  mon_w;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_resp", {60'b0, resp_hartid}, 64'hFFFF);
      end else begin
        mon_e = expq.pop_front();
        check("resp_data", resp_data, mon_e.data);
        check("resp_hartid", resp_hartid, mon_e.hart);
        check("resp_err", resp_err, mon_e.err);
        check("resp_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      if (wrq.size() == 0) begin
        check("unexpected_write", {52'b0, mem_addr}, 64'hFFFF);
      end else begin
        mon_w = wrq.pop_front();
        check("wr_addr", mem_addr, mon_w.addr);
        check("wr_data", mem_wdata, mon_w.data);
        check("wr_rs_store_op", rs_store_op, 1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_junk();
    req_op     = 4'($urandom());
    req_addr   = AW'($urandom());
    req_wdata  = DW'($urandom());
    req_hartid = HW'($urandom());
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int n = 0;
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) check(name, 0, 1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] w,
                       input logic [HW-1:0] h);
    exp_t e;
    bit ok;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w; req_hartid = h;
    wait_ready("ready_timeout", ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    model(op, a, w, h, e);
    e.acc = cyc;
    expq.push_back(e);
    // Keep junk requests valid while busy; none may be accepted.
    for (int i = 0; i < e.lat; i++) begin
      @(negedge clk);
      if (i == e.lat - 1) req_valid = 1'b0;
      else drive_junk();
    end
  endtask

  logic [AW-1:0] pool [16] = '{12'h010, 12'h020, 12'h030, 12'h031, 12'h040, 12'h080,
                               12'h100, 12'h101, 12'h1FF, 12'h200, 12'h3A5, 12'h444,
                               12'h7FF, 12'h800, 12'hABC, 12'hFFF};

  task automatic drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || wrq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_resp_left"}, expq.size(), 0);
    check({name, "_wr_left"}, wrq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] v, w, old;
    logic [AW-1:0] a;
    logic [HW-1:0] h;
    logic [3:0]    op;
    int            r;
    bit            ok;

    req_valid = 1'b0;
    drive_junk();
    // Preload the address pool in both memories while reset is held.
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       v = 32'hDEADBEEF;
        1:       v = 32'hFFFFFFFF;
        2, 3:    v = 32'h80000000;
        default: v = $urandom();
      endcase
      @(negedge clk);
      pre_we = 1'b1; pre_addr = pool[i]; pre_data = v;
      ref_mem[pool[i]] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;

    check("rst_req_ready", req_ready, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rs_store_op", rs_store_op, 0);
    check("rst_rs_sc_op", rs_store_cond_op, 0);
    check("rst_rs_lr_op", rs_load_reserved_op, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rs_addr", rs_addr, 0);
    check("rst_rs_mhartid", rs_mhartid, 0);
    check("rst_resp_hartid", resp_hartid, 0);
    reset = 1'b0;

    // Directed scenarios
    issue(4'd0, 12'h010, 32'h0, 4'd3);
    issue(4'd5, 12'h020, 32'd2, 4'd1);
    issue(4'd9, 12'h030, 32'd1, 4'd4);
    issue(4'd11, 12'h031, 32'd1, 4'd4);
    issue(4'd2, 12'h040, 32'h0, 4'd5);
    issue(4'd3, 12'h040, 32'h55, 4'd5);
    issue(4'd3, 12'h040, 32'h55, 4'd5);
    issue(4'd2, 12'h080, 32'h0, 4'd2);
    issue(4'd1, 12'h080, 32'h1234, 4'd7);
    issue(4'd3, 12'h080, 32'h99, 4'd2);
    issue(4'd14, 12'h123, 32'h777, 4'd9);
    drain("directed");

    // Randomised traffic with a small address pool and few harts for contention
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 19);
      op = (r <= 15) ? 4'(r) : ((r <= 17) ? 4'd2 : 4'd3);
      a = pool[$urandom_range(0, 15)];
      h = ($urandom_range(0, 3) == 0) ? HW'($urandom_range(0, 15)) : HW'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       w = 32'h80000000;
        1:       w = 32'h7FFFFFFF;
        2:       w = 32'd1;
        3:       w = ref_mem[a];
        default: w = $urandom();
      endcase
      issue(op, a, w, h);
    end
    drain("random");

    // Reset while an AMO is in its write cycle: the write lands, nothing else follows.
    @(negedge clk);
    a = pool[6];
    req_valid = 1'b1; req_op = 4'd5; req_addr = a; req_wdata = 32'd3; req_hartid = 4'd6;
    wait_ready("rst_amo_ready", ok);
    if (ok) begin
      old = ref_mem[a];
      ref_write(a, old + 32'd3);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_amo_we_before", mem_we, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_amo_we_after", mem_we, 0);
      check("rst_amo_resp_valid", resp_valid, 0);
      check("rst_amo_ready", req_ready, 1);
      repeat (6) @(negedge clk);
    end else begin
      req_valid = 1'b0;
    end

    // Reset while a LOAD read is outstanding: the returning data is dropped.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_addr = pool[7]; req_wdata = 0; req_hartid = 4'd8;
    wait_ready("rst_ld_ready", ok);
    @(negedge clk);
    req_valid = 1'b0;
    if (ok) begin
      check("rst_ld_mem_en", mem_en, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_ld_ready_after", req_ready, 1);
      check("rst_ld_mem_en_after", mem_en, 0);
      check("rst_ld_resp_valid", resp_valid, 0);
      repeat (6) @(negedge clk);
    end

    issue(4'd0, pool[6], 32'h0, 4'd9);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
